clkdiv_ctrl: RTL and testbench

Run-time programmable clock-divider controller. Owns a modulo-D period counter, produces a registered divided output and a one-cycle period tick as clock enables for downstream logic, and sequences divisor changes and start/stop so that every output period is complete: no truncated or glitched periods. Sits between the configuration/host logic and the blocks that consume divided enables. Single clock domain throughout.

---
 rtl/clkdiv_ctrl.sv | 140 ++++++++++++++
 tb/tb_clkdiv_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clkdiv_ctrl.sv
// clkdiv_ctrl: programmable clock-divider controller.
// Emits whole-period divided enables; divisor swaps land on period edges.
module clkdiv_ctrl #(
  parameter int          WIDTH     = 14,
  parameter int unsigned N_DEFAULT = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             div_out,
  output logic             tick,
  output logic             busy,
  output logic [WIDTH-1:0] cur_div
);

  localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(N_DEFAULT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STOP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] cur_div_q, cur_div_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             div_out_q, div_out_d;
  logic             tick_q, tick_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;

  logic             xfer;
  logic             cfg_zero;
  logic             cfg_take;
  logic             wrap;
  logic             run_d;

  // Handshake and period-end decode from registered state.
  always_comb begin
    xfer     = cfg_valid & ~pend_vld_q;
    cfg_zero = (cfg_div == '0);
    cfg_take = xfer & ~cfg_zero;
    wrap     = (state_q != S_IDLE) &&
               (cnt_q == cur_div_q - 1'b1);
  end

  // Next-state: counter, divisor, pending slot and FSM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_div_d  = cur_div_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    err_d      = xfer & cfg_zero;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (pend_vld_q) begin
          cur_div_d  = pend_q;
          pend_vld_d = 1'b0;
        end
        if (cfg_take) begin
          cur_div_d = cfg_div;
        end
        if (en) begin
          state_d = S_RUN;
        end
      end
      S_RUN, S_STOP: begin
        if (wrap) begin
          cnt_d = '0;
          if (pend_vld_q) begin
            cur_div_d  = pend_q;
            pend_vld_d = 1'b0;
          end
          state_d = en ? S_RUN : S_IDLE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = en ? S_RUN : S_STOP;
        end
        if (cfg_take) begin
          pend_d     = cfg_div;
          pend_vld_d = 1'b1;
        end
      end
      default: begin
        state_d    = S_IDLE;
        cnt_d      = '0;
        pend_vld_d = 1'b0;
      end
    endcase
  end

  // Outputs follow the next count so they line up with cnt.
  always_comb begin
    run_d     = (state_d != S_IDLE);
    tick_d    = run_d && (cnt_d == '0);
    div_out_d = run_d && (cnt_d >= (cur_div_d >> 1));
    busy_d    = run_d;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cur_div_q  <= DIV_RST;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      div_out_q  <= 1'b0;
      tick_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_div_q  <= cur_div_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      div_out_q  <= div_out_d;
      tick_q     <= tick_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  assign cfg_ready = ~pend_vld_q;
  assign cfg_err   = err_q;
  assign div_out   = div_out_q;
  assign tick      = tick_q;
  assign busy      = busy_q;
  assign cur_div   = cur_div_q;

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// tb_clkdiv_ctrl: directed bench for clkdiv_ctrl.
// Per-cycle model comparison plus literal period counts.
module tb_clkdiv_ctrl;

  localparam int W = 14;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         en = 1'b0;
  logic         cfg_valid = 1'b0;
  logic [W-1:0] cfg_div = '0;
  logic         cfg_ready;
  logic         cfg_err;
  logic         div_out;
  logic         tick;
  logic         busy;
  logic [W-1:0] cur_div;

  int n_err = 0;
  int n_chk = 0;
  bit chk_on = 1'b0;

  // model: active flag, position in period, divisor, pending (0 = none)
  bit m_act;
  int m_cnt;
  int m_div;
  int m_pend;
  bit m_err;

  clkdiv_ctrl #(.WIDTH(W), .N_DEFAULT(10)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .cfg_valid(cfg_valid),
    .cfg_div(cfg_div),
    .cfg_ready(cfg_ready),
    .cfg_err(cfg_err),
    .div_out(div_out),
    .tick(tick),
    .busy(busy),
    .cur_div(cur_div)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model of the divider, one step per clock.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act  <= 1'b0;
      m_cnt  <= 0;
      m_div  <= 10;
      m_pend <= 0;
      m_err  <= 1'b0;
    end else begin
      automatic bit a = m_act;
      automatic int c = m_cnt;
      automatic int d = m_div;
      automatic int p = m_pend;
      automatic bit x = cfg_valid && (m_pend == 0);
      automatic int v = int'(cfg_div);
      if (!a) begin
        if (p != 0) begin
          d = p;
          p = 0;
        end
        if (x && v != 0) d = v;
        c = 0;
        a = en;
      end else begin
        if (c == d - 1) begin
          c = 0;
          if (p != 0) begin
            d = p;
            p = 0;
          end
          a = en;
        end else begin
          c = c + 1;
        end
        if (x && v != 0) p = v;
      end
      m_act  <= a;
      m_cnt  <= c;
      m_div  <= d;
      m_pend <= p;
      m_err  <= x && (v == 0);
    end
  end

  // Compare all outputs against the model mid-cycle.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("tick", int'(tick), int'(m_act && m_cnt == 0));
      chk("div_out", int'(div_out), int'(m_act && m_cnt >= m_div / 2));
      chk("busy", int'(busy), int'(m_act));
      chk("cfg_ready", int'(cfg_ready), int'(m_pend == 0));
      chk("cfg_err", int'(cfg_err), int'(m_err));
      chk("cur_div", int'(cur_div), m_div);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic measure(input int n, output int t, output int h,
                         output int b);
    t = 0;
    h = 0;
    b = 0;
    repeat (n) begin
      @(negedge clk);
      t += int'(tick);
      h += int'(div_out);
      b += int'(busy);
    end
  endtask

  task automatic load(input int d);
    cfg_valid = 1'b1;
    cfg_div   = W'(d);
    step(1);
    cfg_valid = 1'b0;
    cfg_div   = '0;
  endtask

  int t, h, b;

  initial begin
    #1 rst_n = 1'b0;
    chk_on = 1'b1;
    step(3);
    chk("rst_cur_div", int'(cur_div), 10);
    chk("rst_ready", int'(cfg_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_div_out", int'(div_out), 0);
    rst_n = 1'b1;
    step(1);

    // default divisor 10
    en = 1'b1;
    @(posedge clk);
    measure(40, t, h, b);
    chk("d10_ticks", t, 4);
    chk("d10_high", h, 20);
    chk("d10_busy", b, 40);
    chk("d10_cur_div", int'(cur_div), 10);

    // D=7 loaded in IDLE
    en = 1'b0;
    step(20);
    load(7);
    chk("d7_loaded", int'(cur_div), 7);
    en = 1'b1;
    @(posedge clk);
    measure(28, t, h, b);
    chk("d7_ticks", t, 4);
    chk("d7_high", h, 16);

    // change 10 -> 4 at cnt=3 while running
    en = 1'b0;
    step(20);
    load(10);
    en = 1'b1;
    step(1);
    step(3);
    cfg_valid = 1'b1;
    cfg_div   = W'(4);
    step(1);
    cfg_valid = 1'b0;
    cfg_div   = '0;
    chk("pend_ready_low", int'(cfg_ready), 0);
    chk("pend_cur_div", int'(cur_div), 10);
    measure(22, t, h, b);
    chk("chg_ticks", t, 4);
    chk("chg_high", h, 13);
    chk("chg_ready_back", int'(cfg_ready), 1);
    chk("chg_cur_div", int'(cur_div), 4);

    // stop at cnt=2 completes the period
    en = 1'b0;
    step(10);
    load(10);
    en = 1'b1;
    step(1);
    step(2);
    en = 1'b0;
    measure(8, t, h, b);
    chk("stop_ticks", t, 0);
    chk("stop_high", h, 5);
    chk("stop_busy", b, 8);
    @(negedge clk);
    chk("stop_idle_busy", int'(busy), 0);
    chk("stop_idle_div", int'(div_out), 0);

    // drop at cnt=2, reassert at cnt=6
    en = 1'b1;
    step(1);
    step(2);
    en = 1'b0;
    step(4);
    en = 1'b1;
    measure(24, t, h, b);
    chk("re_ticks", t, 2);
    chk("re_high", h, 14);
    chk("re_busy", b, 24);

    // zero divisor rejected
    step(1);
    load(0);
    chk("zero_err", int'(cfg_err), 1);
    chk("zero_cur_div", int'(cur_div), 10);
    chk("zero_ready", int'(cfg_ready), 1);
    step(1);
    chk("zero_err_clr", int'(cfg_err), 0);

    // D=1: constant tick and div_out
    en = 1'b0;
    step(12);
    load(1);
    en = 1'b1;
    @(posedge clk);
    measure(10, t, h, b);
    chk("d1_ticks", t, 10);
    chk("d1_high", h, 10);

    // reset mid-period with a pending divisor
    en = 1'b0;
    step(3);
    load(10);
    en = 1'b1;
    step(4);
    load(5);
    chk("rst_pend_ready", int'(cfg_ready), 0);
    step(1);
    rst_n = 1'b0;
    #1;
    chk("arst_tick", int'(tick), 0);
    chk("arst_div", int'(div_out), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_cur_div", int'(cur_div), 10);
    chk("arst_ready", int'(cfg_ready), 1);
    en = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
    en = 1'b1;
    @(posedge clk);
    measure(20, t, h, b);
    chk("post_rst_ticks", t, 2);
    chk("post_rst_high", h, 10);
    chk("post_rst_cur_div", int'(cur_div), 10);

    en = 1'b0;
    step(12);
    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
